// File: rtl/seg_scan_chain.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_chain
//  Description : Multiplexed hex display scanner driving a daisy-chained
//                74HC595 shift register pair (ds/shclk/stclk). Each digit
//                gets a decimal point and a blanking control. Also debounces
//                two raw active-low push-keys into one-cycle press pulses.
//                Optional macro LEADING_ZERO_BLANK_EN darkens leading zero
//                digits at frame snapshot time.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_chain #(
  parameter int NUM_DIGITS     = 8,
  parameter int SHCLK_DIV      = 4,
  parameter int DIGIT_HOLD     = 1024,
  parameter int DEBOUNCE       = 4096,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    key0,
  input  logic                    key1,
  output logic                    key0_pulse,
  output logic                    key1_pulse,
  output logic                    ds,
  output logic                    shclk,
  output logic                    stclk,
  output logic                    frame_done
);

  localparam int c_B  = 8 + NUM_DIGITS;
  localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_BW = $clog2(c_B);
  localparam int c_DW = $clog2(SHCLK_DIV + 1);
  localparam int c_HW = $clog2(DIGIT_HOLD + 1);
  localparam int c_KW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [c_IW-1:0]         r_idx;
  logic [c_BW-1:0]         r_bit;
  logic [c_DW-1:0]         r_div;
  logic                    r_phase;
  logic [c_HW-1:0]         r_hold;
  logic [c_B-1:0]          r_word;
  logic                    r_ds;
  logic                    r_shclk;
  logic                    r_stclk;
  logic                    r_frame_done;
  logic [4*NUM_DIGITS-1:0] r_frm_digits;
  logic [NUM_DIGITS-1:0]   r_frm_dp;
  logic [NUM_DIGITS-1:0]   r_frm_blank;

  logic                    w_snap;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [4*NUM_DIGITS-1:0] w_src_digits;
  logic [NUM_DIGITS-1:0]   w_src_dp;
  logic [NUM_DIGITS-1:0]   w_src_blank;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blk;
  logic [6:0]              w_hex;
  logic [7:0]              w_seg_raw;
  logic [7:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [c_B-1:0]          w_word;

  // Leading-zero mask over the live inputs; only consumed at snapshot time
  always_comb begin
    w_lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic v_run;
      v_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (v_run && (digits[4*i +: 4] == 4'h0)) w_lz[i] = 1'b1;
        else                                     v_run = 1'b0;
      end
    end
`endif
  end

  // Digit 0's LOAD reads the live inputs (same cycle they are captured);
  // every other digit reads the frame register
  assign w_snap       = (r_state == S_LOAD) && (r_idx == '0);
  assign w_src_digits = w_snap ? digits         : r_frm_digits;
  assign w_src_dp     = w_snap ? dp             : r_frm_dp;
  assign w_src_blank  = w_snap ? (blank | w_lz) : r_frm_blank;

  // Select the current digit's nibble, dp and blank, plus its one-hot select
  always_comb begin
    w_nib = 4'h0;
    w_dp  = 1'b0;
    w_blk = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(r_idx)) begin
        w_nib = w_src_digits[4*i +: 4];
        w_dp  = w_src_dp[i];
        w_blk = w_src_blank[i];
      end
    end
    w_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i == int'(r_idx)) && !w_blk) w_sel[i] = 1'b1;
    end
  end

  // Hex to a..g segment pattern
  always_comb begin
    case (w_nib)
      4'h0:    w_hex = 7'h3F;
      4'h1:    w_hex = 7'h06;
      4'h2:    w_hex = 7'h5B;
      4'h3:    w_hex = 7'h4F;
      4'h4:    w_hex = 7'h66;
      4'h5:    w_hex = 7'h6D;
      4'h6:    w_hex = 7'h7D;
      4'h7:    w_hex = 7'h07;
      4'h8:    w_hex = 7'h7F;
      4'h9:    w_hex = 7'h6F;
      4'hA:    w_hex = 7'h77;
      4'hB:    w_hex = 7'h7C;
      4'hC:    w_hex = 7'h39;
      4'hD:    w_hex = 7'h5E;
      4'hE:    w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
  end

  assign w_seg_raw = w_blk ? 8'h00 : {w_dp, w_hex};
  assign w_seg     = (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;
  assign w_word    = {w_seg, w_sel};

  // Scan FSM: load word, shift it out MSB first, latch, hold, next digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_LOAD;
      r_idx        <= '0;
      r_bit        <= '0;
      r_div        <= '0;
      r_phase      <= 1'b0;
      r_hold       <= '0;
      r_word       <= '0;
      r_ds         <= 1'b0;
      r_shclk      <= 1'b0;
      r_stclk      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frm_digits <= '0;
      r_frm_dp     <= '0;
      r_frm_blank  <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (r_idx == '0) begin
            r_frm_digits <= digits;
            r_frm_dp     <= dp;
            r_frm_blank  <= blank | w_lz;
          end
          r_word  <= w_word;
          r_bit   <= c_BW'(c_B - 1);
          r_ds    <= w_word[c_B-1];
          r_shclk <= 1'b0;
          r_div   <= '0;
          r_phase <= 1'b0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_div == c_DW'(SHCLK_DIV - 1)) begin
            r_div <= '0;
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_shclk <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_shclk <= 1'b0;
              if (r_bit == '0) begin
                r_stclk <= 1'b1;
                r_state <= S_LATCH;
              end else begin
                r_bit <= r_bit - c_BW'(1);
                r_ds  <= r_word[r_bit - c_BW'(1)];
              end
            end
          end else begin
            r_div <= r_div + c_DW'(1);
          end
        end
        S_LATCH: begin
          if (r_div == c_DW'(SHCLK_DIV - 1)) begin
            r_div   <= '0;
            r_stclk <= 1'b0;
            r_hold  <= '0;
            r_state <= S_HOLD;
          end else begin
            r_div <= r_div + c_DW'(1);
          end
        end
        S_HOLD: begin
          if (r_hold == c_HW'(DIGIT_HOLD - 1)) begin
            r_state <= S_LOAD;
            if (r_idx == c_IW'(NUM_DIGITS - 1)) begin
              r_idx        <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_idx <= r_idx + c_IW'(1);
            end
          end else begin
            r_hold <= r_hold + c_HW'(1);
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign ds         = r_ds;
  assign shclk      = r_shclk;
  assign stclk      = r_stclk;
  assign frame_done = r_frame_done;

  logic [1:0] w_key_raw;
  logic [1:0] w_key_pulse;
  assign w_key_raw = {key1, key0};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]      r_sync;
    logic            r_prev;
    logic            r_level;
    logic [c_KW-1:0] r_cnt;
    logic            r_pulse;

    // Synchronise, then accept a new level only after it stays put long enough
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync  <= 2'b11;
        r_prev  <= 1'b1;
        r_level <= 1'b1;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_key_raw[k]};
        r_prev  <= r_sync[1];
        r_pulse <= 1'b0;
        if ((r_sync[1] == r_level) || (r_sync[1] != r_prev)) begin
          r_cnt <= '0;
        end else if (r_cnt == c_KW'(DEBOUNCE - 1)) begin
          r_cnt   <= '0;
          r_level <= r_sync[1];
          r_pulse <= ~r_sync[1];
        end else begin
          r_cnt <= r_cnt + c_KW'(1);
        end
      end
    end

    assign w_key_pulse[k] = r_pulse;
  end

  assign key0_pulse = w_key_pulse[0];
  assign key1_pulse = w_key_pulse[1];

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_chain
//  Description : Directed self-checking bench for seg_scan_chain with
//                NUM_DIGITS=4, SHCLK_DIV=2, DIGIT_HOLD=8, DEBOUNCE=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp = 4'b0000;
  logic [3:0]  blank = 4'b0000;
  logic        key0 = 1'b1;
  logic        key1 = 1'b1;
  logic        key0_pulse, key1_pulse, ds, shclk, stclk, frame_done;

  int checks = 0;
  int failures = 0;

  seg_scan_chain #(
    .NUM_DIGITS(4), .SHCLK_DIV(2), .DIGIT_HOLD(8), .DEBOUNCE(16), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank),
    .key0(key0), .key1(key1), .key0_pulse(key0_pulse), .key1_pulse(key1_pulse),
    .ds(ds), .shclk(shclk), .stclk(stclk), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // cycle number since reset release (0 = first cycle with rst low)
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Observation: rebuild latched words from the serial lines, log events
  logic [11:0] words [0:63];
  int          rise_cyc [0:63];
  int          fd_cyc [0:15];
  int          nw = 0, nfd = 0;
  logic [15:0] sh = '0;
  logic        prev_sh = 1'b0, prev_st = 1'b0;
  int          k0_cnt = 0, k1_cnt = 0, k0_last = -1, k1_last = -1;

  always @(negedge clk) begin
    if (rst) begin
      sh      = '0;
      prev_sh = 1'b0;
      prev_st = 1'b0;
    end else begin
      if (shclk && !prev_sh) sh = {sh[14:0], ds};
      if (stclk && !prev_st && nw < 64) begin
        words[nw]    = sh[11:0];
        rise_cyc[nw] = cyc;
        nw++;
      end
      if (frame_done && nfd < 16) begin
        fd_cyc[nfd] = cyc;
        nfd++;
      end
      if (key0_pulse) begin k0_cnt++; k0_last = cyc; end
      if (key1_pulse) begin k1_cnt++; k1_last = cyc; end
      prev_sh = shclk;
      prev_st = stclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int t;
    t = 0;
    while (cyc < n && t < 5000) begin @(negedge clk); t++; end
  endtask

  task automatic wait_words(input int n, input string tag);
    int t;
    t = 0;
    while (nw < n && t < 3000) begin @(negedge clk); t++; end
    check(tag, (nw >= n), 1'b1);
  endtask

  int base, edge_cyc, t;

  initial begin
    // reset state
    repeat (5) @(negedge clk);
    check("rst_ds", ds, 1'b0);
    check("rst_shclk", shclk, 1'b0);
    check("rst_stclk", stclk, 1'b0);
    check("rst_pulses", {key0_pulse, key1_pulse}, 2'b00);
    check("rst_frame_done", frame_done, 1'b0);

    // release: this cycle is cycle 0
    rst = 1'b0;
    wait_cyc(48);
    check("stclk_c48", stclk, 1'b0);
    wait_cyc(49);
    check("stclk_c49", stclk, 1'b1);
    wait_cyc(50);
    check("stclk_c50", stclk, 1'b1);
    wait_cyc(51);
    check("stclk_c51", stclk, 1'b0);
    check("first_rise", rise_cyc[0], 49);
    check("word_d0_4", words[0], 12'h991);

    // inputs change during digit 1: frame 0 keeps its snapshot
    wait_cyc(80);
    digits = 16'hFFFF;
    wait_words(4, "frame0_timeout");
    check("word_d1_3", words[1], 12'hB02);
    check("word_d2_2", words[2], 12'hA44);
    check("word_d3_1", words[3], 12'hF98);
    check("rise_d3", rise_cyc[3], 226);

    // frame 1 shows F everywhere; set up dp/blank for frame 2
    wait_cyc(300);
    check("frame_done_0", fd_cyc[0], 236);
    digits = 16'h1234;
    dp     = 4'b0100;
    blank  = 4'b1000;
    wait_words(8, "frame1_timeout");
    check("word_F_d0", words[4], 12'h8E1);
    check("word_F_d1", words[5], 12'h8E2);
    check("word_F_d3", words[7], 12'h8E8);

    // frame 2: dp on digit 2, digit 3 blanked; set up leading zeros for frame 3
    wait_cyc(500);
    digits = 16'h0050;
    dp     = 4'b0000;
    blank  = 4'b0000;
    wait_words(12, "frame2_timeout");
    check("frame_done_1", fd_cyc[1], 472);
    check("word_dp_d2", words[10], 12'h244);
    check("word_blank_d3", words[11], 12'hFF0);
    check("word_dp_d0", words[8], 12'h991);

    // frame 3: 0050
    wait_cyc(720);
    digits = 16'h1234;
    wait_words(16, "frame3_timeout");
    check("word_lz_d0", words[12], 12'hC01);
    check("word_lz_d1", words[13], 12'h922);
`ifdef LEADING_ZERO_BLANK_EN
    check("word_lz_d2", words[14], 12'hFF0);
    check("word_lz_d3", words[15], 12'hFF0);
`else
    check("word_lz_d2", words[14], 12'hC04);
    check("word_lz_d3", words[15], 12'hC08);
`endif
    check("frame_done_2", fd_cyc[2], 708);

    // debounce: bouncing key0 then held low
    check("no_early_pulse", k0_cnt + k1_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      key0 = ~key0;
      repeat (3) @(negedge clk);
    end
    key0 = 1'b0;
    edge_cyc = cyc;
    repeat (30) @(negedge clk);
    check("k0_one_pulse", k0_cnt, 1);
    check("k0_latency_ok", ((k0_last - edge_cyc) >= 18) && ((k0_last - edge_cyc) <= 20), 1'b1);
    check("k1_quiet", k1_cnt, 0);
    key0 = 1'b1;
    repeat (30) @(negedge clk);
    check("k0_release_none", k0_cnt, 1);

    // simultaneous presses
    key0 = 1'b0;
    key1 = 1'b0;
    repeat (30) @(negedge clk);
    check("k0_second", k0_cnt, 2);
    check("k1_first", k1_cnt, 1);
    check("k_simultaneous", k0_last, k1_last);
    key0 = 1'b1;
    key1 = 1'b1;
    repeat (30) @(negedge clk);

    // reset in the middle of a shift
    t = 0;
    while (!shclk && t < 400) begin @(negedge clk); t++; end
    check("shift_seen", shclk, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_shclk", shclk, 1'b0);
    check("midrst_ds", ds, 1'b0);
    check("midrst_stclk", stclk, 1'b0);
    @(negedge clk);
    base = nw;
    rst = 1'b0;
    wait_words(base + 1, "postrst_timeout");
    check("postrst_rise", rise_cyc[base], 49);
    check("postrst_word", words[base], 12'h991);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_chain.md
Name: seg_scan_chain

Overview:
- Parametrised successor to the board's fixed 7-segment driver.
- Scans NUM_DIGITS multiplexed hex digits out through a daisy-chain of 74HC595 shift registers (ds/shclk/stclk), with per-digit decimal point and blanking.
- Debounces two raw push-keys into one-cycle press pulses.
- Sits between the slow PLL clock domain and the board display/key pins; the parent logic supplies the digit values.

Parameters:
NUM_DIGITS, 8, digits scanned; 1..8
SHCLK_DIV, 4, system cycles per shclk half-period; >=1
DIGIT_HOLD, 1024, cycles a latched digit is held before the next is shifted; >=1
DEBOUNCE, 4096, cycles a synchronised key level must be stable before it is accepted
SEG_ACTIVE_LOW, 1, 1 inverts the segment byte (common-anode parts)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
digits  in  4*NUM_DIGITS  hex value per digit; digit i = digits[4i+3:4i]
dp  in  NUM_DIGITS  decimal point per digit
blank  in  NUM_DIGITS  1 = digit fully dark
key0  in  1  raw key, active-low, asynchronous
key1  in  1  raw key, active-low, asynchronous
key0_pulse  out  1  one-cycle pulse per debounced press
key1_pulse  out  1  one-cycle pulse per debounced press
ds  out  1  serial data to 595 chain
shclk  out  1  595 shift clock
stclk  out  1  595 storage/latch clock
frame_done  out  1  one-cycle pulse after the last digit's hold ends

Behaviour:
- Reset state: ds=0, shclk=0, stclk=0, key pulses=0, frame_done=0, digit index=0, FSM=LOAD, debounced key levels=1 (released), debounce counters=0.
- Reset taken at any point, including mid-shift, returns immediately to that state.
- Frame snapshot:
  - In LOAD with index 0, digits/dp/blank are captured into a frame register.
  - All digits of a frame use that snapshot; input changes mid-frame take effect next frame.
- Segment byte: bit0..6 = a..g, bit7 = dp.
  - Hex map: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - dp ORs bit7.
  - blank forces the byte to 00.
  - SEG_ACTIVE_LOW inverts the final byte.
- Select field: NUM_DIGITS bits, one-hot bit i for the current digit i, active-high; all-zero when that digit is blanked.
- Shift word: {seg[7:0], sel[NUM_DIGITS-1:0]}, B = 8+NUM_DIGITS bits, shifted MSB first.
- FSM:
  - LOAD (1 cycle): build word, bit counter = B-1.
  - SHIFT: per bit, shclk low for SHCLK_DIV cycles with ds driven at the start of the low phase, then shclk high for SHCLK_DIV cycles. After B bits go to LATCH; shclk ends low.
  - LATCH: stclk high for SHCLK_DIV cycles, then low.
  - HOLD: DIGIT_HOLD cycles. Index increments, wrapping from NUM_DIGITS-1 to 0. On wrap, frame_done pulses on the cycle HOLD exits. Then go to LOAD.
- Cycles per digit = 1 + 2*SHCLK_DIV*B + SHCLK_DIV + DIGIT_HOLD; defaults give 1157.
- ds holds its last value outside SHIFT.
- Debounce (each key):
  - Two-flop synchroniser, then counter.
  - Counter clears whenever the synced level equals the accepted level or changes; the accepted level updates when the counter reaches DEBOUNCE-1 with a stable differing level.
  - An accepted 1->0 transition produces a one-cycle pulse. Release produces no pulse.
  - The two keys are independent; simultaneous presses give simultaneous pulses.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: at frame snapshot, digits of value 0 from index NUM_DIGITS-1 downward, up to the first nonzero digit, are treated as blanked, dp included. Digit 0 is never auto-blanked. Explicit blank is still ORed in.
- When undefined: zeros display normally.

Test Plan:
1. Params NUM_DIGITS=4, SHCLK_DIV=2, DIGIT_HOLD=8: release rst at cycle 0 -> all outputs 0 during reset; first stclk rise at cycle 49, stays high 2 cycles; next LOAD at cycle 59; frame_done pulses once every 236 cycles.
2. digits=16'h1234, dp=0, SEG_ACTIVE_LOW=1 -> digit0 shifts 1001_1001_0001 ('4' = ~66); digit3 shifts 1111_1001_1000 ('1' = ~06).
3. dp=4'b0100 -> digit2 byte = ~(5B|80) = 24. blank=4'b1000 -> digit3 shifts 1111_1111_0000.
4. Change digits from 16'h1234 to 16'hFFFF during digit1 -> digits 2,3 still show 2,1; next frame shows F everywhere (byte 8E).
5. DEBOUNCE=16: key0 toggles every 3 cycles for 30 cycles, then held low -> exactly one key0_pulse, 18-20 cycles after the final edge; release produces none; key1_pulse stays 0.
6. LEADING_ZERO_BLANK_EN with digits=16'h0050 -> digits 3,2 sel=0000 and seg=FF; digit1 '5' (92); digit0 '0' (C0) shown. Undefined: digit3 shows C0.
